ffn_stream_loader: RTL

- Parametrised streaming front-end for the ffn systolic core, replacing fixed-width 4x4 parallel port wiring.
- Accepts data and weight words one at a time over a valid/ready input stream and deserialises them into the core's packed vectors.
- Starts the core, waits for its done with a timeout, then serialises the N accumulator results back out over a valid/ready output stream.
- Sits between the host/DMA stream fabric and the ffn core instance in the top level.

---
 rtl/ffn_pkg.sv | 32 +++
 rtl/ffn_result_serializer.sv | 54 +++++
 rtl/ffn_stream_loader.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/ffn_pkg.sv
// Shared types and helpers for the ffn streaming front-end.
// No logic, no latency.
// No flow control.
package ffn_pkg;

    localparam int FFN_DATA_WIDTH = 16;
    localparam int FFN_NEURON_NUM = 4;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD_D = 3'd1,
        ST_LOAD_W = 3'd2,
        ST_RUN    = 3'd3,
        ST_DRAIN  = 3'd4
    } ffn_ld_state_e;

    // Bit offset of a slot in a packed vector whose slot 0 sits in the MSBs.
    function automatic int unsigned ffn_slot_lsb(input int unsigned slot,
                                                 input int unsigned nslots,
                                                 input int unsigned width);
        return (nslots - 1 - slot) * width;
    endfunction

    // Bit offset of weight w[row][col] in the row-major packed weight matrix.
    function automatic int unsigned ffn_wslot_lsb(input int unsigned row,
                                                  input int unsigned col,
                                                  input int unsigned n,
                                                  input int unsigned width);
        return ffn_slot_lsb(row * n + col, n * n, width);
    endfunction

endpackage

// File: rtl/ffn_result_serializer.sv
// Captures the core accumulator vector and streams its elements out, element 0 first.
// Latency: first word valid the cycle after i_load; one word per cycle when unstalled.
// Backpressure: word and index hold while i_rdy is low; o_last marks the final handshake.
module ffn_result_serializer
    import ffn_pkg::*;
#(
    parameter int DATA_WIDTH = FFN_DATA_WIDTH,
    parameter int NEURON_NUM = FFN_NEURON_NUM
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           i_load,
    input  logic [DATA_WIDTH*NEURON_NUM-1:0] i_acc,
    input  logic                           i_rdy,
    output logic                           o_vld,
    output logic [DATA_WIDTH-1:0]          o_dat,
    output logic                           o_last
);
    localparam int IW = (NEURON_NUM > 1) ? $clog2(NEURON_NUM) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(NEURON_NUM - 1);

    logic [DATA_WIDTH*NEURON_NUM-1:0] r_res;
    logic [IW-1:0]                    r_idx;
    logic                             r_vld;
    logic [DATA_WIDTH-1:0]            w_elem [NEURON_NUM];

    for (genvar s = 0; s < NEURON_NUM; s++) begin : g_elem
        assign w_elem[s] = r_res[ffn_slot_lsb(s, NEURON_NUM, DATA_WIDTH) +: DATA_WIDTH];
    end

    assign o_vld  = r_vld;
    assign o_dat  = r_vld ? w_elem[r_idx] : '0;
    assign o_last = r_vld & i_rdy & (r_idx == LAST_IDX);

    // Result capture, element index advance on handshake, valid drop after the last element.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_res <= '0;
            r_idx <= '0;
            r_vld <= 1'b0;
        end else if (i_load) begin
            r_res <= i_acc;
            r_idx <= '0;
            r_vld <= 1'b1;
        end else if (r_vld && i_rdy) begin
            if (r_idx == LAST_IDX) begin
                r_vld <= 1'b0;
            end else begin
                r_idx <= r_idx + 1'b1;
            end
        end
    end

endmodule

// File: rtl/ffn_stream_loader.sv
// Deserialises data/weight words for the ffn core, runs it with a timeout, serialises results out.
// Latency: 1 + N + N*N + 1 + core latency + N cycles from start to done_o when unstalled.
// Backpressure: in_ready_o only in load states; result words hold while out_ready_i is low.
module ffn_stream_loader
    import ffn_pkg::*;
#(
    parameter int DATA_WIDTH     = FFN_DATA_WIDTH,
    parameter int NEURON_NUM     = FFN_NEURON_NUM,
    parameter int LAYER_W        = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   start_i,
    input  logic [LAYER_W-1:0]                     layers_i,
    input  logic [DATA_WIDTH-1:0]                  in_data_i,
    input  logic                                   in_valid_i,
    output logic                                   in_ready_o,
    output logic [DATA_WIDTH*NEURON_NUM-1:0]        core_data_o,
    output logic [DATA_WIDTH*NEURON_NUM*NEURON_NUM-1:0] core_weight_o,
    output logic [LAYER_W-1:0]                     core_layers_o,
    output logic                                   core_start_o,
    input  logic [DATA_WIDTH*NEURON_NUM-1:0]        core_acc_i,
    input  logic                                   core_done_i,
    output logic [DATA_WIDTH-1:0]                  out_data_o,
    output logic                                   out_valid_o,
    input  logic                                   out_ready_i,
    output logic                                   busy_o,
    output logic                                   done_o,
    output logic                                   err_o
);
    localparam int N  = NEURON_NUM;
    localparam int DV = DATA_WIDTH * N;
    localparam int WV = DATA_WIDTH * N * N;
    localparam int CW = $clog2(N * N + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES);
    localparam logic [CW-1:0] LAST_D = CW'(N - 1);
    localparam logic [CW-1:0] LAST_W = CW'(N * N - 1);
    localparam logic [TW-1:0] LAST_T = TW'(TIMEOUT_CYCLES - 1);

    ffn_ld_state_e      r_state, w_state_nxt;
    logic [CW-1:0]      r_cnt;
    logic [TW-1:0]      r_tmo;
    logic [DV-1:0]      r_data, w_data_nxt;
    logic [WV-1:0]      r_weight, w_weight_nxt;
    logic [LAYER_W-1:0] r_layers;
    logic               r_core_start, r_done, r_err;
    logic               w_ld_d, w_ld_w, w_xfer;
    logic               w_start_ok, w_start_bad, w_d_last, w_w_last;
    logic               w_core_done, w_timeout, w_drain_last;

    assign w_ld_d     = (r_state == ST_LOAD_D);
    assign w_ld_w     = (r_state == ST_LOAD_W);
    assign in_ready_o = w_ld_d | w_ld_w;
    assign w_xfer     = in_valid_i & in_ready_o;

    // Word k lands in slot k; every other slot keeps its value.
    for (genvar s = 0; s < N; s++) begin : g_dslot
        localparam int LSB = ffn_slot_lsb(s, N, DATA_WIDTH);
        assign w_data_nxt[LSB +: DATA_WIDTH] = (w_ld_d && w_xfer && r_cnt == CW'(s)) ?
                                               in_data_i : r_data[LSB +: DATA_WIDTH];
    end
    for (genvar r = 0; r < N; r++) begin : g_wrow
        for (genvar c = 0; c < N; c++) begin : g_wcol
            localparam int LSB = ffn_wslot_lsb(r, c, N, DATA_WIDTH);
            assign w_weight_nxt[LSB +: DATA_WIDTH] = (w_ld_w && w_xfer && r_cnt == CW'(r * N + c)) ?
                                                     in_data_i : r_weight[LSB +: DATA_WIDTH];
        end
    end

    // Job state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and job events; done from the core beats a simultaneous timeout.
    always_comb begin
        w_state_nxt = r_state;
        w_start_ok  = 1'b0;
        w_start_bad = 1'b0;
        w_d_last    = 1'b0;
        w_w_last    = 1'b0;
        w_core_done = 1'b0;
        w_timeout   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start_i) begin
                    if (layers_i != '0) begin
                        w_start_ok  = 1'b1;
                        w_state_nxt = ST_LOAD_D;
                    end else begin
                        w_start_bad = 1'b1;
                    end
                end
            end
            ST_LOAD_D: begin
                if (w_xfer && r_cnt == LAST_D) begin
                    w_d_last    = 1'b1;
                    w_state_nxt = ST_LOAD_W;
                end
            end
            ST_LOAD_W: begin
                if (w_xfer && r_cnt == LAST_W) begin
                    w_w_last    = 1'b1;
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                if (core_done_i) begin
                    w_core_done = 1'b1;
                    w_state_nxt = ST_DRAIN;
                end else if (r_tmo == LAST_T) begin
                    w_timeout   = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_DRAIN: begin
                if (w_drain_last) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Load registers, word/timeout counters and the registered status pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_data       <= '0;
            r_weight     <= '0;
            r_layers     <= '0;
            r_cnt        <= '0;
            r_tmo        <= '0;
            r_core_start <= 1'b0;
            r_done       <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            r_data       <= w_data_nxt;
            r_weight     <= w_weight_nxt;
            r_core_start <= w_w_last;
            r_done       <= w_start_bad | w_timeout | w_drain_last;
            if (w_start_ok) begin
                r_layers <= layers_i;
                r_err    <= 1'b0;
            end else if (w_start_bad || w_timeout) begin
                r_err <= 1'b1;
            end
            if (w_start_ok || w_d_last || w_w_last) begin
                r_cnt <= '0;
            end else if (w_xfer) begin
                r_cnt <= r_cnt + 1'b1;
            end
            r_tmo <= (r_state == ST_RUN) ? r_tmo + 1'b1 : '0;
        end
    end

    ffn_result_serializer #(
        .DATA_WIDTH (DATA_WIDTH),
        .NEURON_NUM (NEURON_NUM)
    ) u_ser (
        .clk    (clk),
        .rst    (rst),
        .i_load (w_core_done),
        .i_acc  (core_acc_i),
        .i_rdy  (out_ready_i),
        .o_vld  (out_valid_o),
        .o_dat  (out_data_o),
        .o_last (w_drain_last)
    );

    assign core_data_o   = r_data;
    assign core_weight_o = r_weight;
    assign core_layers_o = r_layers;
    assign core_start_o  = r_core_start;
    assign busy_o        = (r_state != ST_IDLE);
    assign done_o        = r_done;
    assign err_o         = r_err;

endmodule
